sobel_window_shifter: RTL

Parametrised multi-row pixel window shifter for the Sobel pipeline. It sits between the line buffers/memory read port and the Sobel kernel. It accepts one packed word of pixels per row per load and presents a sliding window of WINPIX pixels per row, advancing one pixel per pop. Compared with the fixed 4-row, 16-bit shifter, it adds parametric geometry, ready/valid handshakes on both sides, line-end tail handling and short-line detection.

---
 rtl/sobel_pkg.sv | 22 ++
 rtl/sobel_row_shifter.sv | 71 +++++++
 rtl/sobel_window_shifter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window shifter: default geometry,
// FSM state encoding and the fill-counter width helper.
package sobel_pkg;

   localparam int unsigned DEF_ROWS    = 4;
   localparam int unsigned DEF_PIXW    = 16;
   localparam int unsigned DEF_WORDPIX = 4;
   localparam int unsigned DEF_WINPIX  = 2;
   localparam int unsigned DEF_CNTW    = 24;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_RUN   = 2'd1,
      ST_TAIL  = 2'd2
   } state_t;

   // Width needed to count 0..2*WORDPIX buffered pixels.
   function automatic int unsigned fill_width(input int unsigned wordpix);
      return $clog2(2 * wordpix + 1);
   endfunction

endpackage

// File: rtl/sobel_row_shifter.sv
// One row of the window shifter: a 2*WORDPIX pixel register, oldest pixel
// at the MSB end, with shift-by-one, insert-word-at-offset and (optionally)
// clear. The top WINPIX pixels form the row's window.
// SOBEL_SHIFT_CLEAR_EN: when defined, the register resets to 0 and the
// clear input zeroes it; otherwise the register has no reset and stale
// pixels remain in vacated slots.
module sobel_row_shifter
   import sobel_pkg::*;
#(
   parameter int unsigned PIXW    = DEF_PIXW,
   parameter int unsigned WORDPIX = DEF_WORDPIX,
   parameter int unsigned WINPIX  = DEF_WINPIX,
   parameter int unsigned FW      = fill_width(DEF_WORDPIX)
) (
   input  logic                      clk,
`ifdef SOBEL_SHIFT_CLEAR_EN
   input  logic                      reset,
   input  logic                      clear,
`endif
   input  logic                      shift,
   input  logic                      load,
   input  logic [FW-1:0]             ins_pos,
   input  logic [WORDPIX*PIXW-1:0]   word,
   output logic [WINPIX*PIXW-1:0]    win
);

   localparam int unsigned BUFPIX = 2 * WORDPIX;
   localparam int unsigned BUFW   = BUFPIX * PIXW;

   logic [BUFW-1:0] data;
   logic [BUFW-1:0] nxt;

   // Shift first, then drop the new word at slot ins_pos counted from the top.
   always_comb begin
      nxt = data;
      if (shift) begin
         nxt = {data[BUFW-PIXW-1:0], {PIXW{1'b0}}};
      end
      if (load) begin
         for (int unsigned p = 0; p <= WORDPIX; p++) begin
            if (ins_pos == FW'(p)) begin
               nxt[(BUFPIX-WORDPIX-p)*PIXW +: WORDPIX*PIXW] = word;
            end
         end
      end
`ifdef SOBEL_SHIFT_CLEAR_EN
      if (clear) begin
         nxt = '0;
      end
`endif
   end

`ifdef SOBEL_SHIFT_CLEAR_EN
   // Pixel register, cleared on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data <= '0;
      end else begin
         data <= nxt;
      end
   end
`else
   // Pixel register, no reset: contents are qualified by the fill count.
   always_ff @(posedge clk) begin
      data <= nxt;
   end
`endif

   assign win = data[BUFW-1 -: WINPIX*PIXW];

endmodule

// File: rtl/sobel_window_shifter.sv
// Multi-row sliding-window shifter feeding the Sobel kernel. Accepts one
// WORDPIX-pixel word per row per load and presents a WINPIX-pixel window
// per row, advancing one pixel per pop, with line-end tail handling and
// short-line detection.
// SOBEL_SHIFT_CLEAR_EN: when defined, pixel storage resets to 0 and vacated
// or discarded slots are zeroed; control behaviour is unaffected.
module sobel_window_shifter
   import sobel_pkg::*;
#(
   parameter int unsigned ROWS    = DEF_ROWS,
   parameter int unsigned PIXW    = DEF_PIXW,
   parameter int unsigned WORDPIX = DEF_WORDPIX,
   parameter int unsigned WINPIX  = DEF_WINPIX,
   parameter int unsigned CNTW    = DEF_CNTW
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [ROWS*WORDPIX*PIXW-1:0] in_data,
   input  logic                         in_valid,
   input  logic                         in_last,
   output logic                         in_ready,
   output logic [ROWS*WINPIX*PIXW-1:0]  out_data,
   output logic                         out_valid,
   output logic                         out_last,
   input  logic                         out_ready,
   output logic [CNTW-1:0]              win_count,
   output logic                         short_line
);

   localparam int unsigned FW = fill_width(WORDPIX);

   state_t          state;
   state_t          state_next;
   logic [FW-1:0]   fill;
   logic [FW-1:0]   fill_next;
   logic            last_pend;
   logic            last_pend_next;
   logic [FW-1:0]   ins_pos;
   logic            load;
   logic            pop;
   logic            line_done;
   logic            short_det;
   logic            line_clear;

   assign in_ready   = !last_pend && (fill <= FW'(WORDPIX));
   assign out_valid  = (fill >= FW'(WINPIX));
   assign out_last   = (state == ST_TAIL) && (fill == FW'(WINPIX));
   assign load       = in_valid && in_ready;
   assign pop        = out_valid && out_ready;
   assign line_done  = pop && out_last;
   assign short_det  = (state == ST_TAIL) && !out_valid;
   assign line_clear = line_done || short_det;

   // Next fill/tail/state; on a combined pop+load the word lands one slot
   // higher because the shift is applied first.
   always_comb begin
      state_next     = state;
      fill_next      = fill;
      last_pend_next = last_pend;
      ins_pos        = fill;
      if (line_clear) begin
         fill_next      = '0;
         last_pend_next = 1'b0;
         state_next     = ST_EMPTY;
      end else begin
         if (pop) begin
            fill_next = fill_next - FW'(1);
            ins_pos   = fill - FW'(1);
         end
         if (load) begin
            fill_next = fill_next + FW'(WORDPIX);
            if (in_last) begin
               last_pend_next = 1'b1;
            end
         end
         if (last_pend_next) begin
            state_next = ST_TAIL;
         end else if (fill_next >= FW'(WINPIX)) begin
            state_next = ST_RUN;
         end else begin
            state_next = ST_EMPTY;
         end
      end
   end

   // State, fill and pending-tail registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_EMPTY;
         fill      <= '0;
         last_pend <= 1'b0;
      end else begin
         state     <= state_next;
         fill      <= fill_next;
         last_pend <= last_pend_next;
      end
   end

   // Per-line window counter (saturating) and short-line pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_count  <= '0;
         short_line <= 1'b0;
      end else begin
         short_line <= short_det;
         if (line_clear) begin
            win_count <= '0;
         end else if (pop && (win_count != '1)) begin
            win_count <= win_count + CNTW'(1);
         end
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      sobel_row_shifter #(
         .PIXW    (PIXW),
         .WORDPIX (WORDPIX),
         .WINPIX  (WINPIX),
         .FW      (FW)
      ) u_row (
         .clk     (clk),
`ifdef SOBEL_SHIFT_CLEAR_EN
         .reset   (reset),
         .clear   (line_clear),
`endif
         .shift   (pop),
         .load    (load),
         .ins_pos (ins_pos),
         .word    (in_data[r*WORDPIX*PIXW +: WORDPIX*PIXW]),
         .win     (out_data[r*WINPIX*PIXW +: WINPIX*PIXW])
      );
   end

endmodule
